// File: rtl/stopwatch_lap.sv
// stopwatch_lap: count-up mm:ss:hs stopwatch with a lap snapshot held on the display.
// Rev 1.0 - initial release.
`default_nettype none

module stopwatch_lap #(
  parameter int TICK_DIV = 250_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop_n,
  input  logic       lap_n,
  output logic [6:0] disp_mm,
  output logic [5:0] disp_ss,
  output logic [6:0] disp_hs,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2,
    S_OVF  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic ss_meta_q,  ss_meta_d,  ss_sync_q,  ss_sync_d;
  logic ss_prev_q,  ss_prev_d,  ss_press_q, ss_press_d;
  logic lap_meta_q, lap_meta_d, lap_sync_q, lap_sync_d;
  logic lap_prev_q, lap_prev_d, lap_press_q, lap_press_d;

  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0] mm_q, mm_d, hs_q, hs_d;
  logic [5:0] ss_q, ss_d;
  logic [6:0] snap_mm_q, snap_mm_d, snap_hs_q, snap_hs_d;
  logic [5:0] snap_ss_q, snap_ss_d;
  logic       lap_q, lap_d;

  logic       tick;
  logic       at_max;
  logic       lap_go;
  logic [6:0] mm_inc, hs_inc;
  logic [5:0] ss_inc;

  // Buttons idle high; the press pulse is registered so nothing from the pins reaches an output combinationally.
  always_comb begin
    ss_meta_d   = start_stop_n;
    ss_sync_d   = ss_meta_q;
    ss_prev_d   = ss_sync_q;
    ss_press_d  = ss_prev_q & ~ss_sync_q;
    lap_meta_d  = lap_n;
    lap_sync_d  = lap_meta_q;
    lap_prev_d  = lap_sync_q;
    lap_press_d = lap_prev_q & ~lap_sync_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      ss_prev_q   <= 1'b1;
      ss_press_q  <= 1'b0;
      lap_meta_q  <= 1'b1;
      lap_sync_q  <= 1'b1;
      lap_prev_q  <= 1'b1;
      lap_press_q <= 1'b0;
    end else begin
      ss_meta_q   <= ss_meta_d;
      ss_sync_q   <= ss_sync_d;
      ss_prev_q   <= ss_prev_d;
      ss_press_q  <= ss_press_d;
      lap_meta_q  <= lap_meta_d;
      lap_sync_q  <= lap_sync_d;
      lap_prev_q  <= lap_prev_d;
      lap_press_q <= lap_press_d;
    end
  end

  assign tick   = (state_q == S_RUN) && (div_q == DIV_LAST);
  assign at_max = (mm_q == 7'd99) && (ss_q == 6'd59) && (hs_q == 7'd99);
  assign lap_go = lap_press_q & ~ss_press_q;

  always_comb begin
    hs_inc = hs_q + 7'd1;
    ss_inc = ss_q;
    mm_inc = mm_q;
    if (hs_q == 7'd99) begin
      hs_inc = 7'd0;
      ss_inc = ss_q + 6'd1;
      if (ss_q == 6'd59) begin
        ss_inc = 6'd0;
        mm_inc = mm_q + 7'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    hs_d      = hs_q;
    snap_mm_d = snap_mm_q;
    snap_ss_d = snap_ss_q;
    snap_hs_d = snap_hs_q;
    lap_d     = lap_q;

    case (state_q)
      S_IDLE: begin
        if (ss_press_q) state_d = S_RUN;
      end
      S_RUN: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (lap_go) begin
          if (lap_q) begin
            lap_d = 1'b0;
          end else begin
            snap_mm_d = mm_q;
            snap_ss_d = ss_q;
            snap_hs_d = hs_q;
            lap_d     = 1'b1;
          end
        end
        if (ss_press_q) state_d = S_STOP;
        // Saturate rather than wrap; overflow outranks a simultaneous stop.
        if (tick) begin
          if (at_max) begin
            state_d = S_OVF;
          end else begin
            mm_d = mm_inc;
            ss_d = ss_inc;
            hs_d = hs_inc;
          end
        end
      end
      S_STOP: begin
        if (ss_press_q) begin
          state_d = S_RUN;
        end else if (lap_go) begin
          if (lap_q) begin
            lap_d = 1'b0;
          end else begin
            mm_d    = 7'd0;
            ss_d    = 6'd0;
            hs_d    = 7'd0;
            div_d   = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_OVF: begin
        if (lap_go) begin
          mm_d    = 7'd0;
          ss_d    = 6'd0;
          hs_d    = 7'd0;
          div_d   = '0;
          lap_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      mm_q      <= 7'd0;
      ss_q      <= 6'd0;
      hs_q      <= 7'd0;
      snap_mm_q <= 7'd0;
      snap_ss_q <= 6'd0;
      snap_hs_q <= 7'd0;
      lap_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      hs_q      <= hs_d;
      snap_mm_q <= snap_mm_d;
      snap_ss_q <= snap_ss_d;
      snap_hs_q <= snap_hs_d;
      lap_q     <= lap_d;
    end
  end

  assign disp_mm    = lap_q ? snap_mm_q : mm_q;
  assign disp_ss    = lap_q ? snap_ss_q : ss_q;
  assign disp_hs    = lap_q ? snap_hs_q : hs_q;
  assign running    = (state_q == S_RUN);
  assign overflow   = (state_q == S_OVF);
  assign lap_active = lap_q;

endmodule

`default_nettype wire
